// File: rtl/rf_write_sched.sv
// rf_write_sched: arbitrates N register-file write requesters and runs a full-file clear sweep.
// Optional feature: define RF_SCHED_RR_EN for rotating priority; the default build uses fixed priority (requester 0 highest).
module rf_write_sched #(
    parameter int W = 8,
    parameter int D = 3,
    parameter int N = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [N-1:0]   req,
    input  logic [N*D-1:0] req_addr,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   gnt,
    input  logic           clr_start,
    output logic           busy,
    output logic           clr_done,
    output logic           WriteEn,
    output logic [D-1:0]   Waddr,
    output logic [W-1:0]   DataIn
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    localparam logic [D-1:0] LAST = '1;
    typedef enum logic {IDLE, CLR} state_t;
    state_t state, state_n;
    logic [D-1:0] cnt;
    logic [PW-1:0] sel, idx;
    logic hit;
`ifdef RF_SCHED_RR_EN
    logic [PW-1:0] ptr;
`endif
    assign busy = (state == CLR);
    // Pick the highest-priority active requester; scanning from lowest priority up lets the last hit win.
    always_comb begin
        sel = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
`ifdef RF_SCHED_RR_EN
            idx = PW'((int'(ptr) + k) % N);
`else
            idx = PW'(k);
`endif
            if (req[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
        gnt = (Reset && state == IDLE && !clr_start && hit) ? N'(1) << sel : '0;
    end
    // Next-state: clear request takes priority in IDLE; sweep ends on its last address.
    always_comb begin
        state_n = state;
        if (state == IDLE && clr_start)
            state_n = CLR;
        else if (state == CLR && cnt == LAST)
            state_n = IDLE;
    end
    // State, sweep counter, priority pointer and the registered write port.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            WriteEn  <= 1'b0;
            Waddr    <= '0;
            DataIn   <= '0;
            clr_done <= 1'b0;
`ifdef RF_SCHED_RR_EN
            ptr      <= '0;
`endif
        end else begin
            state    <= state_n;
            WriteEn  <= (state == CLR) || (|gnt);
            clr_done <= (state == CLR) && (cnt == LAST);
            if (state == CLR) begin
                Waddr  <= cnt;
                DataIn <= '0;
                cnt    <= cnt + 1'b1;
            end else if (|gnt) begin
                Waddr  <= req_addr[sel*D +: D];
                DataIn <= req_data[sel*W +: W];
`ifdef RF_SCHED_RR_EN
                ptr    <= (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_rf_write_sched.sv
// tb_rf_write_sched: randomized scoreboard bench for rf_write_sched (either RF_SCHED_RR_EN build).
module tb_rf_write_sched;
    localparam int W = 8;
    localparam int D = 3;
    localparam int N = 3;
    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*D-1:0] req_addr = '0;
    logic [N*W-1:0] req_data = '0;
    logic           clr_start = 1'b0;
    logic [N-1:0]   gnt;
    logic           busy, clr_done, WriteEn;
    logic [D-1:0]   Waddr;
    logic [W-1:0]   DataIn;

    typedef struct {
        logic         we;
        logic [D-1:0] a;
        logic [W-1:0] d;
        logic         done;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_bad = 0;

    bit           m_sweep = 0;
    int           m_saddr = 0;
    int           m_ptr = 0;
    logic [D-1:0] m_a = '0;
    logic [W-1:0] m_d = '0;

    rf_write_sched #(.W(W), .D(D), .N(N)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn)
    );

    always #5 Clk = ~Clk;

    // One cycle: apply inputs, check grant/busy against the model, queue the expected write.
    task automatic cyc(input logic rst_n, input logic clr, input logic [N-1:0] r,
                       input logic [N*D-1:0] a, input logic [N*W-1:0] d);
        logic [N-1:0] eg;
        exp_t e;
        int w, base, id;
        @(negedge Clk);
        Reset = rst_n;
        clr_start = clr;
        req = r;
        req_addr = a;
        req_data = d;
        #1;
        n_cmp++;
        if (busy !== m_sweep) begin
            n_bad++;
            $display("FAIL busy: got %b want %b at %0t", busy, m_sweep, $time);
        end
        eg = '0;
        w = -1;
        e.we = 1'b0;
        e.done = 1'b0;
        if (!rst_n) begin
            m_sweep = 0;
            m_ptr = 0;
            m_a = '0;
            m_d = '0;
        end else if (m_sweep) begin
            e.we = 1'b1;
            m_a = m_saddr[D-1:0];
            m_d = '0;
            e.done = (m_saddr == 2**D - 1);
            m_saddr++;
            if (m_saddr == 2**D) m_sweep = 0;
        end else if (clr) begin
            m_sweep = 1;
            m_saddr = 0;
        end else begin
`ifdef RF_SCHED_RR_EN
            base = m_ptr;
`else
            base = 0;
`endif
            for (int k = 0; k < N; k++) begin
                id = (base + k) % N;
                if (w < 0 && r[id]) w = id;
            end
            if (w >= 0) begin
                eg[w] = 1'b1;
                e.we = 1'b1;
                m_a = a[w*D +: D];
                m_d = d[w*W +: W];
                m_ptr = (w + 1) % N;
            end
        end
        e.a = m_a;
        e.d = m_d;
        q.push_back(e);
        n_cmp++;
        if (gnt !== eg) begin
            n_bad++;
            $display("FAIL gnt: got %b want %b at %0t", gnt, eg, $time);
        end
    endtask

    task automatic cyc_r(input logic rst_n, input logic clr, input logic [N-1:0] r);
        cyc(rst_n, clr, r, (N*D)'($urandom), (N*W)'($urandom));
    endtask

    // Monitor: after each edge, compare the registered write port with the oldest expectation.
    always @(posedge Clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_cmp++;
            if ({WriteEn, Waddr, DataIn, clr_done} !== {mon_e.we, mon_e.a, mon_e.d, mon_e.done}) begin
                n_bad++;
                $display("FAIL write: got we=%b a=%0d d=%h done=%b want we=%b a=%0d d=%h done=%b at %0t",
                         WriteEn, Waddr, DataIn, clr_done, mon_e.we, mon_e.a, mon_e.d, mon_e.done, $time);
            end
        end
    end

    initial begin
        cyc_r(0, 0, '0);
        cyc_r(0, 0, '0);
        cyc(1, 0, 3'b001, 9'd5, 24'h0000A5);
        cyc_r(1, 0, '0);
        cyc_r(0, 0, '0);
        repeat (6) cyc_r(1, 0, 3'b111);
        cyc_r(1, 1, 3'b010);
        repeat (10) cyc_r(1, 0, 3'b010);
        cyc_r(1, 1, 3'b000);
        repeat (4) cyc_r(1, 0, 3'b011);
        cyc_r(0, 0, 3'b011);
        repeat (4) cyc_r(1, 0, 3'b000);
        cyc_r(1, 1, 3'b000);
        repeat (3) cyc_r(1, 0, 3'b000);
        cyc_r(1, 1, 3'b101);
        repeat (8) cyc_r(1, 0, 3'b000);
        repeat (400) cyc_r(($urandom_range(0, 49) != 0), ($urandom_range(0, 24) == 0), N'($urandom));
        @(posedge Clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected writes left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_write_sched.md
RF_WRITE_SCHED -- requirements
Module: rf_write_sched

Interface
REQ-001 SHALL have parameter W, default 8, register data width.
REQ-002 SHALL have parameter D, default 3, register address width (2**D registers).
REQ-003 SHALL have parameter N, default 3, number of write requesters.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req  input  N  per-requester write request.
REQ-007 SHALL have port req_addr  input  N*D  packed write addresses; slice i belongs to requester i.
REQ-008 SHALL have port req_data  input  N*W  packed write data; slice i belongs to requester i.
REQ-009 SHALL have port gnt  output  N  one-hot combinational grant; transfer occurs on an edge where req[i] and gnt[i] are both high.
REQ-010 SHALL have port clr_start  input  1  request a full register-file clear sweep.
REQ-011 SHALL have port busy  output  1  high while the clear sweep is in progress.
REQ-012 SHALL have port clr_done  output  1  one-cycle pulse marking the final clear write.
REQ-013 SHALL have port WriteEn  output  1  registered register-file write enable.
REQ-014 SHALL have port Waddr  output  D  registered register-file write address.
REQ-015 SHALL have port DataIn  output  W  registered register-file write data.

Function
REQ-016 SHALL implement an FSM with states IDLE and CLR.
REQ-017 SHALL, in IDLE, assert at most one gnt bit, and only for a requester whose req is high.
REQ-018 SHALL register the granted requester's address and data onto Waddr/DataIn with WriteEn=1 on the transfer edge, giving one-cycle latency.
REQ-019 SHALL drive WriteEn=0 in the following cycle when no transfer or clear write occurred; Waddr/DataIn then hold their last values.
REQ-020 SHALL hold a rotating priority pointer; after a grant to i, requester (i+1) mod N has highest priority.
REQ-021 SHALL let a requester holding req high be granted again only after its turn comes back round (at most N-1 other grants in between).
REQ-022 SHALL, on clr_start=1 in IDLE, enter CLR on that edge, assert no gnt that cycle, and give clear priority over any simultaneous req.
REQ-023 SHALL, in CLR, issue one write per cycle to addresses 0,1,...,2**D-1 in order with data 0, keep gnt all-zero, and hold busy=1.
REQ-024 SHALL return to IDLE on the edge that issues the write to address 2**D-1; grants may resume in the next cycle.
REQ-025 SHALL pulse clr_done in the cycle WriteEn=1 with Waddr=2**D-1 from the sweep.
REQ-026 SHALL ignore clr_start while in CLR; the sweep is never restarted or extended.
REQ-027 SHALL leave the pointer unchanged during CLR.

Reset
REQ-028 SHALL, on a rising edge with Reset=0, set state IDLE, pointer 0, sweep counter 0, WriteEn=0, Waddr=0, DataIn=0, busy=0, clr_done=0.
REQ-029 SHALL force gnt to zero combinationally while Reset=0.
REQ-030 SHALL abort a sweep in progress when reset is asserted; no further sweep writes occur after reset.

Configuration
REQ-031 SHALL, with macro RF_SCHED_RR_EN defined, use the rotating priority of REQ-020/021.
REQ-032 SHALL, without RF_SCHED_RR_EN, use fixed priority (requester 0 highest), and the pointer logic SHALL be absent.

Verification
REQ-033 SHALL cover: after reset, req=3'b001, req_addr slice0=5, req_data slice0=8'hA5 -> gnt=001 same cycle; next cycle WriteEn=1, Waddr=5, DataIn=A5.
REQ-034 SHALL cover (RR build): req=3'b111 held for 6 cycles -> gnt sequence 001,010,100,001,010,100.
REQ-035 SHALL cover (fixed build): req=3'b111 held for 3 cycles -> gnt=001 every cycle.
REQ-036 SHALL cover: clr_start with req=3'b010 in the same cycle -> no gnt; busy=1 for 8 cycles; Waddr 0..7 with DataIn=0; clr_done coincides with Waddr=7; gnt=010 in the cycle after the last sweep edge.
REQ-037 SHALL cover: Reset=0 during a sweep at address 3 -> next cycle WriteEn=0, busy=0, state IDLE; no writes to addresses 4..7.
REQ-038 SHALL cover: second clr_start pulse during a sweep -> exactly 8 sweep writes and one clr_done.
